// File: rtl/oam_dma_if.sv
// CPU snoop / system bus / PPU port bundle for the OAM DMA engine.
// slave is the DMA side, master is the surrounding system (or bench).
interface oam_dma_if;
  logic [15:0] i_cpu_address;
  logic [7:0]  i_cpu_data;
  logic        i_cpu_rw;
  logic [7:0]  i_data;
  logic        o_cpu_rdy;
  logic        o_bus_master;
  logic [15:0] o_address;
  logic        o_rw;
  logic [7:0]  o_data;
  logic        o_ppu_cs_n;
  logic [2:0]  o_ppu_rs;
  logic        o_ppu_rw;
  logic [7:0]  o_ppu_data;
  logic        o_busy;

  modport slave (
    input  i_cpu_address, i_cpu_data, i_cpu_rw, i_data,
    output o_cpu_rdy, o_bus_master, o_address, o_rw, o_data,
           o_ppu_cs_n, o_ppu_rs, o_ppu_rw, o_ppu_data, o_busy
  );

  modport master (
    output i_cpu_address, i_cpu_data, i_cpu_rw, i_data,
    input  o_cpu_rdy, o_bus_master, o_address, o_rw, o_data,
           o_ppu_cs_n, o_ppu_rs, o_ppu_rw, o_ppu_data, o_busy
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: a CPU write to $4014 halts the CPU and copies one 256-byte page
// into the PPU OAMDATA register, one read/write pair per byte.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | CPU owns the bus, waiting for a $4014 write
// S_HALT  | CPU halted, one cycle to let it release the bus
// S_ALIGN | dummy cycle so every READ falls on an even (odd_q==0) cycle
// S_READ  | drive {page,index} and capture the returned byte
// S_WRITE | write the captured byte to $2004 (PPU OAMDATA)
module oam_dma (
  input  logic     i_clk,
  input  logic     i_reset,
  oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] byte_q, byte_d;
  logic       odd_q;
  logic       trigger;

  assign trigger = (bus.i_cpu_address == 16'h4014) && !bus.i_cpu_rw;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      index_q <= 8'h00;
      byte_q  <= 8'h00;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      byte_q  <= byte_d;
      odd_q   <= ~odd_q;
    end
  end

  always_comb begin
    state_d          = state_q;
    page_d           = page_q;
    index_d          = index_q;
    byte_d           = byte_q;
    bus.o_cpu_rdy    = 1'b0;
    bus.o_bus_master = 1'b0;
    bus.o_address    = 16'h0000;
    bus.o_rw         = 1'b1;
    bus.o_data       = 8'h00;
    bus.o_ppu_cs_n   = 1'b1;
    bus.o_ppu_rs     = 3'd0;
    bus.o_ppu_rw     = 1'b1;
    bus.o_ppu_data   = 8'h00;
    bus.o_busy       = 1'b1;

    case (state_q)
      S_IDLE: begin
        bus.o_cpu_rdy = 1'b1;
        bus.o_busy    = 1'b0;
        if (trigger) begin
          page_d  = bus.i_cpu_data;
          index_d = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        state_d = odd_q ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        bus.o_bus_master = 1'b1;
        bus.o_address    = {page_q, index_q};
        byte_d           = bus.i_data;
        state_d          = S_WRITE;
      end
      S_WRITE: begin
        bus.o_bus_master = 1'b1;
        bus.o_address    = 16'h2004;
        bus.o_rw         = 1'b0;
        bus.o_data       = byte_q;
        bus.o_ppu_cs_n   = 1'b0;
        bus.o_ppu_rs     = 3'd4;
        bus.o_ppu_rw     = 1'b0;
        bus.o_ppu_data   = byte_q;
        // index wraps inside the page; the page register is never touched
        index_d          = index_q + 8'd1;
        state_d          = (index_q == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected read addresses and PPU write data
// are queued at trigger time and retired as the DMA produces bus cycles.
module tb_oam_dma;

  logic clk;
  logic rst;
  logic tb_odd;
  logic mon_en;
  logic prev_cs_n;
  int   n_vec;
  int   n_err;
  int   low_run;
  int   last_low;
  int   wr_seen;

  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];

  oam_dma_if bus ();

  oam_dma dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return (a == 16'hFFFF) ? 8'hA5 : a[7:0];
  endfunction

  always_comb bus.i_data = mem_rd(bus.o_address);

  always @(posedge clk) tb_odd <= rst ? 1'b0 : ~tb_odd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_cpu_rdy) begin
        check("idle_out",
              {bus.o_bus_master, bus.o_busy, bus.o_ppu_cs_n, bus.o_address, bus.o_rw,
               bus.o_data, bus.o_ppu_rs, bus.o_ppu_rw, bus.o_ppu_data},
              {1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h00, 3'd0, 1'b1, 8'h00});
        if (low_run != 0) begin
          last_low = low_run;
          low_run  = 0;
        end
      end else begin
        low_run++;
      end
      if (bus.o_bus_master && bus.o_rw) begin
        check("rd_phase", {63'd0, tb_odd}, 64'd0);
        check("rd_expected", {63'd0, rd_q.size() != 0}, 64'd1);
        if (rd_q.size() != 0) check("rd_addr", {48'd0, bus.o_address}, {48'd0, rd_q.pop_front()});
      end
      if (!bus.o_ppu_cs_n) begin
        check("wr_bus", {bus.o_rw, bus.o_address, bus.o_ppu_rs, bus.o_ppu_rw, bus.o_bus_master},
              {1'b0, 16'h2004, 3'd4, 1'b0, 1'b1});
        check("wr_b2b", {63'd0, prev_cs_n}, 64'd1);
        check("wr_expected", {63'd0, wr_q.size() != 0}, 64'd1);
        if (wr_q.size() != 0) begin
          logic [7:0] e;
          e = wr_q.pop_front();
          check("wr_ppu_data", {56'd0, bus.o_ppu_data}, {56'd0, e});
          check("wr_bus_data", {56'd0, bus.o_data}, {56'd0, e});
        end
        wr_seen++;
      end
      prev_cs_n = bus.o_ppu_cs_n;
    end
  end

  task automatic cpu_write_4014(input logic [7:0] d);
    bus.i_cpu_address = 16'h4014;
    bus.i_cpu_data    = d;
    bus.i_cpu_rw      = 1'b0;
    @(posedge clk); #1;
    bus.i_cpu_address = 16'h0000;
    bus.i_cpu_data    = 8'h00;
    bus.i_cpu_rw      = 1'b1;
  endtask

  // align_phase: odd value wanted in the trigger cycle (1 -> HALT is even -> ALIGN)
  task automatic trigger(input logic [7:0] page, input logic align_phase);
    int n;
    n = 0;
    while (tb_odd !== align_phase && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {page, i[7:0]};
      rd_q.push_back(a);
      wr_q.push_back(mem_rd(a));
    end
    cpu_write_4014(page);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (bus.o_busy && n < 2000);
    check("idle_timeout", {63'd0, n < 2000}, 64'd1);
    @(negedge clk); #1;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_rd_left"}, rd_q.size(), 64'd0);
    check({tag, "_wr_left"}, wr_q.size(), 64'd0);
  endtask

  task automatic wait_writes(input int target);
    int n;
    n = 0;
    while (wr_seen < target && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("wr_timeout", {63'd0, n < 2000}, 64'd1);
  endtask

  initial begin
    int n;
    n_vec = 0; n_err = 0; low_run = 0; last_low = 0; wr_seen = 0;
    mon_en = 1'b0; prev_cs_n = 1'b1;
    bus.i_cpu_address = 16'h0000;
    bus.i_cpu_data    = 8'h00;
    bus.i_cpu_rw      = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_rdy", {63'd0, bus.o_cpu_rdy}, 64'd1);
    check("rst_busy", {63'd0, bus.o_busy}, 64'd0);
    @(posedge clk); #1;

    // even-page trigger with ALIGN
    trigger(8'h02, 1'b1);
    wait_idle();
    check("align_rdy_low", last_low, 64'd514);
    check_drained("align");

    // no ALIGN, plus a trigger during the final WRITE that must be ignored
    trigger(8'h02, 1'b0);
    n = 0;
    while (rd_q.size() != 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("last_rd_timeout", {63'd0, n < 2000}, 64'd1);
    @(posedge clk); #1;
    cpu_write_4014(8'h09);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("late_trig_busy", {63'd0, bus.o_busy}, 64'd0);
    end
    check("noalign_rdy_low", last_low, 64'd513);
    check_drained("noalign");
    @(posedge clk); #1;

    // top page: last read is $FFFF, last byte A5
    trigger(8'hFF, 1'b1);
    wait_idle();
    check_drained("page_ff");

    // second trigger at byte 10 is ignored
    wr_seen = 0;
    trigger(8'h02, 1'b0);
    wait_writes(10);
    @(posedge clk); #1;
    cpu_write_4014(8'h07);
    wait_idle();
    check("ignored_total_wr", wr_seen, 64'd256);
    check_drained("ignored");

    // reset at byte 100 aborts, then a fresh trigger restarts at index 0
    wr_seen = 0;
    trigger(8'h05, 1'b1);
    wait_writes(100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rd_q.delete();
    wr_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("abort_out", {bus.o_cpu_rdy, bus.o_ppu_cs_n, bus.o_busy, bus.o_bus_master}, {4'b1100});
    wr_seen = 0;
    repeat (6) @(negedge clk);
    check("abort_no_wr", wr_seen, 64'd0);
    @(posedge clk); #1;
    trigger(8'h03, 1'b0);
    wait_idle();
    check("restart_total_wr", wr_seen, 64'd256);
    check_drained("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
